// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with majority voting, parity, framing and break detection
module uart_rx_ext #(
  parameter int N_BIT  = 8,
  parameter int N_TICK = 16,
  parameter int N_STOP = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic             RX,
  input  logic [1:0]       PARITY_MODE,
  output logic             RX_DONE,
  output logic [N_BIT-1:0] DOUT,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             BREAK,
  output logic [2:0]       STATE
);
  localparam int SW = $clog2(N_TICK);
  localparam int NW = $clog2(N_BIT);
  localparam logic [SW-1:0] S_LO  = SW'(N_TICK/2-1);
  localparam logic [SW-1:0] S_MID = SW'(N_TICK/2);
  localparam logic [SW-1:0] S_HI  = SW'(N_TICK/2+1);
  localparam logic [SW-1:0] S_END = SW'(N_TICK-1);
  localparam logic [NW-1:0] N_END = NW'(N_BIT-1);
  localparam logic          K_END = 1'(N_STOP-1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [SW-1:0] s;
  logic [NW-1:0] n;
  logic k;
  logic [1:0] smp, mode;
  logic bit_v, par, perr, ferr, zero_ok;
  logic [N_BIT-1:0] sh;
  logic maj, at_hi, at_end, done, brk_c;
  assign maj    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign at_hi  = TICK && s == S_HI;
  assign at_end = TICK && s == S_END;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {RX, rx_m};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = rx_s ? IDLE : START;
      START:    state_n = (at_hi && maj) ? IDLE : at_end ? DATA : START;
      DATA:     state_n = (at_end && n == N_END) ? (^mode ? PAR : STOP) : DATA;
      PAR:      state_n = at_end ? STOP : PAR;
      STOP:     state_n = done ? (brk_c ? BRK_WAIT : IDLE) : STOP;
      BRK_WAIT: state_n = rx_s ? IDLE : BRK_WAIT;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    done  = state == STOP && at_hi && k == K_END;
    brk_c = sh == '0 && zero_ok && !maj;
    STATE = state;
  end
  // Frame datapath; a new frame starts from a clean slate while idle.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      s <= '0;
      n <= '0;
      k <= 1'b0;
      smp <= 2'b11;
      mode <= 2'b00;
      bit_v <= 1'b1;
      par <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      zero_ok <= 1'b0;
      sh <= '0;
      RX_DONE <= 1'b0;
      DOUT <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR <= 1'b0;
      BREAK <= 1'b0;
    end else begin
      RX_DONE <= done;
      if (state == IDLE) begin
        s <= '0;
        n <= '0;
        k <= 1'b0;
        par <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
        zero_ok <= 1'b1;
        if (!rx_s) mode <= PARITY_MODE;
      end else if (TICK && state != BRK_WAIT) begin
        s <= (s == S_END) ? '0 : s + 1'b1;
        if (s == S_LO) smp[0] <= rx_s;
        if (s == S_MID) smp[1] <= rx_s;
        if (s == S_HI) bit_v <= maj;
        if (state == DATA && s == S_END) begin
          sh <= {bit_v, sh[N_BIT-1:1]};
          par <= par ^ bit_v;
          n <= n + 1'b1;
        end
        if (state == PAR && s == S_END) begin
          perr <= bit_v != (par ^ mode[1]);
          zero_ok <= zero_ok & ~bit_v;
        end
        if (state == STOP && s == S_HI && !maj) ferr <= 1'b1;
        if (state == STOP && s == S_END) k <= k + 1'b1;
        if (done) begin
          DOUT <= sh;
          PARITY_ERR <= perr;
          FRAME_ERR <= ferr | ~maj;
          BREAK <= brk_c;
        end
      end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: frame-level reference model checks two receivers (1 and 2 stop bits) every cycle
module tb_uart_rx_ext;
  localparam int NB = 8, NT = 16, TD = 3;
  typedef struct packed {logic [7:0] d; logic pe, fe, br; logic [3:0] fb;} exp_t;
  logic CLK = 0, RESET = 1, TICK = 0;
  logic [1:0] rx = 2'b11;
  logic [1:0] PARITY_MODE = 2'b00;
  logic [1:0] done, perr, ferr, brk;
  logic [7:0] dout [2];
  logic [2:0] st [2];
  int n_chk = 0, n_fail = 0, tc = 0;
  exp_t eq [2][64];
  int hd [2], tl [2], cur_bit [2];
  exp_t held [2];
  exp_t ce;

  uart_rx_ext #(.N_BIT(NB), .N_TICK(NT), .N_STOP(1)) d1 (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .RX(rx[0]), .PARITY_MODE(PARITY_MODE),
    .RX_DONE(done[0]), .DOUT(dout[0]), .PARITY_ERR(perr[0]), .FRAME_ERR(ferr[0]),
    .BREAK(brk[0]), .STATE(st[0]));
  uart_rx_ext #(.N_BIT(NB), .N_TICK(NT), .N_STOP(2)) d2 (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .RX(rx[1]), .PARITY_MODE(PARITY_MODE),
    .RX_DONE(done[1]), .DOUT(dout[1]), .PARITY_ERR(perr[1]), .FRAME_ERR(ferr[1]),
    .BREAK(brk[1]), .STATE(st[1]));

  always #5 CLK = ~CLK;

  initial forever begin
    @(negedge CLK);
    tc = (tc + 1) % TD;
    TICK = (tc == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected result of a frame from its transmitted bits; sv[k] is the level of stop bit k.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] m, input logic pb,
                                 input logic [1:0] sv, input int ns);
    exp_t r;
    logic pen;
    pen = (m == 2'b01) || (m == 2'b10);
    r.d = d;
    r.pe = pen && (pb != ((^d) ^ (m == 2'b10)));
    r.fe = !sv[0] || (ns == 2 && !sv[1]);
    r.br = (d == 8'h00) && (!pen || !pb) && !sv[ns-1];
    r.fb = 4'd0;
    return r;
  endfunction

  function automatic exp_t lit(input logic [7:0] d, input logic pe, input logic fe, input logic br);
    exp_t r;
    r.d = d; r.pe = pe; r.fe = fe; r.br = br; r.fb = 4'd0;
    return r;
  endfunction

  // Every cycle: outputs hold their last frame result except on an RX_DONE pulse.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        held[i] = '0;
        chk("done_in_reset", 32'(done[i]), 0);
      end else if (done[i]) begin
        if (hd[i] == tl[i]) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: inst %0d got RX_DONE expected none", i);
        end else begin
          ce = eq[i][hd[i] % 64];
          hd[i]++;
          chk("done_bit", 32'(cur_bit[i]), 32'(ce.fb));
          held[i] = ce;
        end
      end
      chk("dout", 32'(dout[i]), 32'(held[i].d));
      chk("parity_err", 32'(perr[i]), 32'(held[i].pe));
      chk("frame_err", 32'(ferr[i]), 32'(held[i].fe));
      chk("break", 32'(brk[i]), 32'(held[i].br));
    end
  end

  task automatic drive(input int i, input logic lv, input int ticks);
    rx[i] = lv;
    repeat (ticks * TD) @(negedge CLK);
  endtask

  task automatic push(input int i, input exp_t e);
    eq[i][tl[i] % 64] = e;
    tl[i]++;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [1:0] m, input logic pflip,
                      input logic [1:0] slow, input bit spike, input bit use_lit, input exp_t le);
    int ns = i + 1;
    int pen = (m == 2'b01 || m == 2'b10) ? 1 : 0;
    logic pb;
    exp_t e;
    pb = (^d) ^ (m == 2'b10) ^ pflip;
    e = use_lit ? le : model(d, m, pb, ~slow, ns);
    e.fb = 4'(NB + pen + ns);
    push(i, e);
    PARITY_MODE = m;
    cur_bit[i] = 0;
    drive(i, 1'b0, NT);
    PARITY_MODE = 2'($urandom);
    for (int b = 0; b < NB; b++) begin
      cur_bit[i] = 1 + b;
      if (spike && b == 3) begin
        drive(i, d[b], 7);
        drive(i, ~d[b], 1);
        drive(i, d[b], 8);
      end else drive(i, d[b], NT);
    end
    if (pen == 1) begin
      cur_bit[i] = 1 + NB;
      drive(i, pb, NT);
    end
    // A low final stop bit is cut just past mid-bit so the restart it causes is a clean false start.
    for (int k = 0; k < ns; k++) begin
      cur_bit[i] = 1 + NB + pen + k;
      drive(i, ~slow[k], (k == ns - 1 && slow[k]) ? NT / 2 + 4 : NT);
    end
    rx[i] = 1'b1;
    cur_bit[i] = 99;
    repeat (NT * TD * 2 + $urandom_range(0, 5)) @(negedge CLK);
  endtask

  task automatic brk_line(input int i, input logic [1:0] m, input bit use_lit, input exp_t le);
    int ns = i + 1;
    int pen = (m == 2'b01 || m == 2'b10) ? 1 : 0;
    exp_t e;
    e = use_lit ? le : model(8'h00, m, 1'b0, 2'b00, ns);
    e.fb = 4'(NB + pen + ns);
    push(i, e);
    PARITY_MODE = m;
    for (int b = 0; b < 12; b++) begin
      cur_bit[i] = b;
      drive(i, 1'b0, NT);
    end
    chk("brk_wait_state", 32'(st[i]), 5);
    rx[i] = 1'b1;
    cur_bit[i] = 99;
    repeat (6) @(negedge CLK);
    chk("brk_release_idle", 32'(st[i]), 0);
    repeat (NT * TD) @(negedge CLK);
  endtask

  task automatic glitch(input int i);
    bit seen = 0;
    rx[i] = 1'b0;
    repeat (4 * TD) begin
      @(negedge CLK);
      seen |= (st[i] == 3'd1);
    end
    rx[i] = 1'b1;
    repeat (30 * TD) begin
      @(negedge CLK);
      seen |= (st[i] == 3'd1);
    end
    chk("glitch_start_seen", 32'(seen), 1);
    chk("glitch_back_idle", 32'(st[i]), 0);
  endtask

  initial begin
    exp_t t;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst_dout", 32'(dout[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_perr", 32'(perr[i]), 0);
      chk("rst_ferr", 32'(ferr[i]), 0);
      chk("rst_brk", 32'(brk[i]), 0);
      chk("rst_state", 32'(st[i]), 0);
    end
    RESET = 0;
    repeat (NT * TD) @(negedge CLK);
    t = model(8'h07, 2'b01, 1'b1, 2'b11, 1);
    chk("pin_even_ok", 32'(t.pe), 0);
    t = model(8'h07, 2'b01, 1'b0, 2'b11, 1);
    chk("pin_even_bad", 32'(t.pe), 1);
    t = model(8'h3C, 2'b10, 1'b1, 2'b01, 2);
    chk("pin_odd_fe", 32'({t.pe, t.fe, t.br}), 32'b010);
    t = model(8'h00, 2'b00, 1'b0, 2'b00, 1);
    chk("pin_brk", 32'({t.pe, t.fe, t.br}), 32'b011);

    send(0, 8'hA5, 2'b00, 1'b0, 2'b00, 0, 1, lit(8'hA5, 0, 0, 0));
    chk("a5_state_idle", 32'(st[0]), 0);
    send(0, 8'h07, 2'b01, 1'b0, 2'b00, 0, 1, lit(8'h07, 0, 0, 0));
    send(0, 8'h07, 2'b01, 1'b1, 2'b00, 0, 1, lit(8'h07, 1, 0, 0));
    send(1, 8'h3C, 2'b10, 1'b0, 2'b10, 0, 1, lit(8'h3C, 0, 1, 0));
    glitch(0);
    send(0, 8'h5A, 2'b00, 1'b0, 2'b00, 1, 1, lit(8'h5A, 0, 0, 0));
    send(0, 8'hA5, 2'b00, 1'b0, 2'b00, 1, 1, lit(8'hA5, 0, 0, 0));
    brk_line(0, 2'b00, 1, lit(8'h00, 0, 1, 1));
    send(0, 8'h55, 2'b00, 1'b0, 2'b00, 0, 1, lit(8'h55, 0, 0, 0));
    brk_line(1, 2'b10, 0, '0);

    PARITY_MODE = 2'b00;
    cur_bit[0] = 0;
    drive(0, 1'b0, NT);
    drive(0, 1'b1, NT * 3 + NT / 2);
    #1 RESET = 1;
    #1;
    chk("mid_rst_dout", 32'(dout[0]), 0);
    chk("mid_rst_done", 32'(done[0]), 0);
    chk("mid_rst_flags", 32'({perr[0], ferr[0], brk[0]}), 0);
    chk("mid_rst_state", 32'(st[0]), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 0;
    cur_bit[0] = 99;
    repeat (NT * TD * 2) @(negedge CLK);
    send(0, 8'h81, 2'b00, 1'b0, 2'b00, 0, 1, lit(8'h81, 0, 0, 0));

    for (int f = 0; f < 30; f++) begin
      int i;
      logic [7:0] d;
      i = $urandom_range(0, 1);
      d = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      send(i, d, 2'($urandom), ($urandom % 4) == 0, ($urandom % 4 == 0) ? 2'($urandom) : 2'b00,
           ($urandom % 3) == 0, 0, '0);
    end
    for (int i = 0; i < 2; i++) chk("all_frames_done", 32'(hd[i]), 32'(tl[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
